// File: rtl/set_bit_iterator.sv
// Walks a captured word and emits the index of each set bit, lowest first,
// one beat per valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for a word; in_ready high, no beat presented
// ITER  | presenting the lowest remaining set bit of the working word
module set_bit_iterator #(
    parameter int WIDTH = 32,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    output logic             out_last,
    output logic             out_empty,
    output logic [IDX_W:0]   out_seq
);

    localparam int SEQ_W = IDX_W + 1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic {IDLE, ITER} state_t;

    state_t           state;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] next_work;

    function automatic logic [IDX_W-1:0] lsb_index(input logic [WIDTH-1:0] w);
        logic [WIDTH-1:0] iso;
        logic [IDX_W-1:0] idx;
        iso = w & (~w + ONE);
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (iso[i]) idx = idx | IDX_W'(i);
        end
        return idx;
    endfunction

    // True for a single set bit and also for zero, so an empty word is its own last beat.
    function automatic logic at_most_one(input logic [WIDTH-1:0] w);
        return (w & (w - ONE)) == '0;
    endfunction

    always_comb begin
        next_work = work & (work - ONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            work      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_index <= '0;
            out_last  <= 1'b0;
            out_empty <= 1'b0;
            out_seq   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state     <= ITER;
                        work      <= in_data;
                        in_ready  <= 1'b0;
                        out_valid <= 1'b1;
                        out_index <= lsb_index(in_data);
                        out_last  <= at_most_one(in_data);
                        out_empty <= (in_data == '0);
                        out_seq   <= '0;
                    end
                end
                ITER: begin
                    if (out_ready) begin
                        if (out_last) begin
                            state     <= IDLE;
                            work      <= '0;
                            in_ready  <= 1'b1;
                            out_valid <= 1'b0;
                            out_index <= '0;
                            out_last  <= 1'b0;
                            out_empty <= 1'b0;
                            out_seq   <= '0;
                        end else begin
                            work      <= next_work;
                            out_index <= lsb_index(next_work);
                            out_last  <= at_most_one(next_work);
                            out_seq   <= out_seq + SEQ_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_set_bit_iterator.sv
// Randomized bench for set_bit_iterator against a bit-scan reference model.
module tb_set_bit_iterator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_index;
    logic        out_last;
    logic        out_empty;
    logic [5:0]  out_seq;

    set_bit_iterator #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
        .out_last(out_last), .out_empty(out_empty), .out_seq(out_seq)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Observations from the most recent run_word call
    int got_idx[$];
    int got_last[$];
    int got_empty[$];
    int got_seq[$];
    int first_delay, valid_cycles, valid_gaps, stab_err, ready_during;
    int post_ready, post_valid, timed_out;

    // Reference: indices of set bits, ascending; a zero word yields one empty beat.
    function automatic void model(input logic [31:0] w, output int idx[$], output int empty);
        idx = {};
        for (int i = 0; i < 32; i++) if (w[i]) idx.push_back(i);
        empty = (w == 32'h0);
        if (empty) idx.push_back(0);
    endfunction

    // Drives one word (called at a negedge) and records every beat; performs no checks.
    task automatic run_word(input logic [31:0] data, input int stall_first, input int ready_pct);
        int n, stalls;
        bit started, done, stalled;
        logic [4:0] p_idx;
        logic p_last, p_empty;
        logic [5:0] p_seq;
        got_idx = {}; got_last = {}; got_empty = {}; got_seq = {};
        first_delay = -1; valid_cycles = 0; valid_gaps = 0; stab_err = 0; ready_during = 0;
        timed_out = 0;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        in_valid = 1'b1;
        in_data = data;
        started = 0; done = 0; stalled = 0; stalls = 0; n = 0;
        p_idx = '0; p_last = 1'b0; p_empty = 1'b0; p_seq = '0;
        while (!done && n < 500) begin
            @(negedge clk); n++;
            in_data = $urandom;
            if (stalled && (!out_valid || out_index !== p_idx || out_last !== p_last ||
                            out_empty !== p_empty || out_seq !== p_seq)) stab_err++;
            stalled = 0;
            if (out_valid) begin
                if (!started) begin started = 1; first_delay = n; end
                valid_cycles++;
                if (in_ready) ready_during++;
                if (stalls < stall_first) begin out_ready = 1'b0; stalls++; end
                else out_ready = ($urandom_range(99) < ready_pct);
                if (out_ready) begin
                    got_idx.push_back(int'(out_index));
                    got_last.push_back(int'(out_last));
                    got_empty.push_back(int'(out_empty));
                    got_seq.push_back(int'(out_seq));
                    if (out_last) begin done = 1; in_valid = 1'b0; end
                end else begin
                    stalled = 1;
                    p_idx = out_index; p_last = out_last; p_empty = out_empty; p_seq = out_seq;
                end
            end else begin
                if (started) valid_gaps++;
                out_ready = 1'(($urandom_range(1)));
            end
        end
        if (!done) begin timed_out = 1; in_valid = 1'b0; end
        @(negedge clk);
        post_ready = int'(in_ready);
        post_valid = int'(out_valid);
    endtask

    task automatic check_word(input string name, input logic [31:0] data);
        int exp[$];
        int empty;
        model(data, exp, empty);
        total_cnt++;
        if (timed_out != 0) $display("FAIL %s timeout: word 0x%08h never finished", name, data);
        else pass_cnt++;
        total_cnt++;
        if (got_idx.size() != exp.size())
            $display("FAIL %s beat_count: got %0d expected %0d", name, got_idx.size(), exp.size());
        else pass_cnt++;
        for (int k = 0; k < exp.size() && k < got_idx.size(); k++) begin
            total_cnt++;
            if (got_idx[k] != exp[k] || got_seq[k] != k || got_last[k] != int'(k == exp.size() - 1) ||
                got_empty[k] != empty)
                $display("FAIL %s beat%0d: got idx=%0d seq=%0d last=%0d empty=%0d expected idx=%0d seq=%0d last=%0d empty=%0d",
                         name, k, got_idx[k], got_seq[k], got_last[k], got_empty[k],
                         exp[k], k, int'(k == exp.size() - 1), empty);
            else pass_cnt++;
        end
        total_cnt++;
        if (stab_err != 0 || ready_during != 0 || valid_gaps != 0 || first_delay != 1)
            $display("FAIL %s protocol: got stab_err=%0d ready_during=%0d gaps=%0d latency=%0d expected 0 0 0 1",
                     name, stab_err, ready_during, valid_gaps, first_delay);
        else pass_cnt++;
        total_cnt++;
        if (post_ready != 1 || post_valid != 0)
            $display("FAIL %s post_idle: got in_ready=%0d out_valid=%0d expected 1 0", name, post_ready, post_valid);
        else pass_cnt++;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b1; in_data = $urandom; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (out_valid !== 1'b0 || out_index !== 5'd0 || out_last !== 1'b0 || out_empty !== 1'b0 || out_seq !== 6'd0)
            $display("FAIL reset_values: got valid=%b idx=%0d last=%b empty=%b seq=%0d expected all 0",
                     out_valid, out_index, out_last, out_empty, out_seq);
        else pass_cnt++;
        rst_n = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL reset_release: got in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
        else pass_cnt++;
        run_word(32'h0000_0001, 0, 100);
        check_word("single", 32'h0000_0001);
    endtask

    task automatic test_sparse;
        run_word(32'h8001_0010, 0, 100);
        check_word("sparse", 32'h8001_0010);
        total_cnt++;
        if (valid_cycles != 3) $display("FAIL sparse_valid_cycles: got %0d expected 3", valid_cycles);
        else pass_cnt++;
    endtask

    task automatic test_backpressure;
        run_word(32'h0000_0006, 5, 100);
        check_word("backpressure", 32'h0000_0006);
        total_cnt++;
        if (valid_cycles != 7) $display("FAIL backpressure_cycles: got %0d expected 7", valid_cycles);
        else pass_cnt++;
    endtask

    task automatic test_zero;
        run_word(32'h0, 0, 100);
        check_word("zero", 32'h0);
    endtask

    task automatic test_top_bit;
        run_word(32'h8000_0000, 2, 100);
        check_word("top_bit", 32'h8000_0000);
    endtask

    task automatic test_back_to_back;
        int b2b_ready;
        run_word(32'hFFFF_FFFF, 0, 100);
        b2b_ready = post_ready;
        check_word("all_ones", 32'hFFFF_FFFF);
        total_cnt++;
        if (valid_cycles != 32) $display("FAIL all_ones_cycles: got %0d expected 32", valid_cycles);
        else pass_cnt++;
        run_word(32'h0000_0002, 0, 100);
        check_word("back_to_back", 32'h0000_0002);
        total_cnt++;
        if (b2b_ready != 1 || first_delay != 1)
            $display("FAIL b2b_accept: got ready=%0d latency=%0d expected 1 1", b2b_ready, first_delay);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        int n, seen;
        bit hit;
        in_valid = 1'b1; in_data = 32'h0000_00F0; out_ready = 1'b1;
        hit = 0; n = 0;
        while (!hit && n < 20) begin
            @(negedge clk); n++;
            in_valid = 1'b0;
            if (out_valid && out_index == 5'd5) hit = 1;
        end
        total_cnt++;
        if (!hit) $display("FAIL reset_mid_reach: index 5 beat not seen within %0d cycles", n);
        else pass_cnt++;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (out_valid !== 1'b0 || out_seq !== 6'd0 || out_index !== 5'd0)
            $display("FAIL reset_mid_async: got valid=%b idx=%0d seq=%0d expected 0 0 0", out_valid, out_index, out_seq);
        else pass_cnt++;
        seen = 0;
        repeat (3) begin @(negedge clk); if (out_valid) seen++; end
        rst_n = 1'b1;
        repeat (2) begin @(negedge clk); if (out_valid) seen++; end
        total_cnt++;
        if (seen != 0) $display("FAIL reset_mid_no_beats: got %0d stray valid cycles expected 0", seen);
        else pass_cnt++;
        run_word(32'h0000_0100, 0, 100);
        check_word("after_reset", 32'h0000_0100);
    endtask

    task automatic test_random;
        logic [31:0] w;
        for (int t = 0; t < 24; t++) begin
            case ($urandom_range(3))
                0: w = $urandom;
                1: w = $urandom & $urandom & $urandom;
                2: w = $urandom | $urandom;
                default: w = (t % 6 == 0) ? 32'h0 : (32'h1 << $urandom_range(31));
            endcase
            run_word(w, int'($urandom_range(2)), 60);
            check_word("random", w);
        end
    endtask

    initial begin
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_sparse();
        test_backpressure();
        test_zero();
        test_top_bit();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/set_bit_iterator.md
Name: set_bit_iterator

Overview:
- Sequential consumer of the LSB-index function: accepts a 32-bit word and emits, one per beat, the index of every set bit, lowest first.
- Each emitted beat clears that bit from an internal working copy.
- Sits between a word-producing stage (interrupt-pending, free-list or request vectors) and a consumer that services one index at a time.
- Valid/ready handshake on both sides.

Parameters:
WIDTH, 32, input word width; must be a power of 2, range 2..64
IDX_W, $clog2(WIDTH), index width (derived; do not override)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_data is valid
in_ready  output  1  block can accept a word
in_data  input  WIDTH  word to iterate
out_valid  output  1  out_* fields are valid
out_ready  input  1  consumer accepts current beat
out_index  output  IDX_W  index of lowest remaining set bit
out_last  output  1  current beat is the final beat for this word
out_empty  output  1  word was all-zero; out_index is don't-care (driven 0)
out_seq  output  IDX_W+1  beat number within current word, 0-based

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
- Values while rst_n=0: state=IDLE, working word=0, out_valid=0, out_index=0, out_last=0, out_empty=0, out_seq=0, in_ready=1 after release.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - ITER: in_ready=0, out_valid=1.
- IDLE -> ITER on in_valid & in_ready. The word is registered and beat 0 is presented the next cycle, so latency is 1 cycle from accept to first out_valid.
- In ITER:
  - out_index = position of lowest set bit of the working word (isolate with w & -w, then encode). Registered and stable while out_valid & ~out_ready.
  - out_last = 1 when the working word has exactly one set bit ((w & (w-1)) == 0), or when out_empty=1.
  - out_empty = 1 only when the accepted word was 0. In that case exactly one beat is emitted with out_index=0, out_last=1, out_seq=0.
- Beat handshake (out_valid & out_ready):
  - Working word clears its lowest set bit; out_seq increments.
  - If out_last=1, go ITER -> IDLE; in_ready=1 on the following cycle. There is no same-cycle bypass.
- Output stability: all out_* hold unchanged while out_valid=1 and out_ready=0, for any number of stall cycles.
- in_data is ignored while in_ready=0. in_valid may stay high; the word is taken only on the IDLE handshake.
- Throughput:
  - Word with N>0 set bits: N beats, plus 1 idle cycle before the next accept.
  - Zero word: 1 beat, plus 1 idle cycle.
- out_seq width IDX_W+1 holds WIDTH-1 with no wrap. The maximum value reached is WIDTH-1, for an all-ones word.
- Bit WIDTH-1 set alone: out_index=WIDTH-1, out_last=1.
- Reset asserted mid-iteration: the in-flight word is discarded immediately (asynchronous), with no further beats. After release, the block is in IDLE with reset values.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid/out_* fields. out_ready affects only next-state.

Test Plan:
- Reset and single word:
  - Stimulus: hold rst_n=0 with in_valid=1, then release; send in_data=32'h0000_0001 with out_ready=1.
  - Required: in_ready=1 after release; one beat out_index=0, out_last=1, out_seq=0; next cycle in_ready=1, out_valid=0.
- Sparse word:
  - Stimulus: in_data=32'h8001_0010, out_ready=1.
  - Required: beats index 4, 16, 31; out_seq 0, 1, 2; out_last only on the 31 beat; 3 consecutive out_valid cycles starting 1 cycle after accept.
- Backpressure:
  - Stimulus: in_data=32'h0000_0006; out_ready=0 for 5 cycles, then 1.
  - Required: out_index=1 held stable for all 5 stall cycles, then index 2 with out_last=1; in_ready stays 0 throughout.
- Zero word:
  - Stimulus: in_data=0.
  - Required: single beat with out_empty=1, out_last=1, out_index=0; then IDLE.
- All-ones:
  - Stimulus: in_data=32'hFFFF_FFFF, out_ready=1.
  - Required: 32 beats with indices 0..31 in order; out_seq reaches 31; out_last only at index 31.
  - Then a back-to-back in_valid with in_data=32'h0000_0002: accepted exactly 1 cycle after the last beat; index 1 emitted.
- Reset mid-operation:
  - Stimulus: in_data=32'h0000_00F0; assert rst_n=0 after the index-5 beat.
  - Required: out_valid drops to 0 asynchronously and no index 6 or 7 beats appear; after release, in_data=32'h0000_0100 yields index 8 with out_seq=0.
